// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, captures {pc, instr} from a
// combinational instruction memory into a small prefetch FIFO, and hands entries to decode.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en,
  output logic [`DATA_WIDTH-1:0]  imem_addr,
  input  logic [`INSTR_WIDTH-1:0] imem_instr,
  input  logic                    redirect_valid,
  input  logic [`DATA_WIDTH-1:0]  redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [`INSTR_WIDTH-1:0] out_instr,
  output logic [`DATA_WIDTH-1:0]  out_pc,
  output logic [31:0]             fetch_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef logic [PW-1:0]           ptr_t;
  typedef logic [PW:0]             cnt_t;
  typedef logic [`DATA_WIDTH-1:0]  addr_t;
  typedef logic [`INSTR_WIDTH-1:0] instr_t;

  localparam cnt_t  FULL       = cnt_t'(DEPTH);
  localparam addr_t ALIGN_MASK = ~addr_t'(3);

  addr_t  pc_mem    [DEPTH];
  instr_t instr_mem [DEPTH];

  addr_t  fetch_pc;
  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  cnt_t   count;
  logic   push;
  logic   pop;

  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = fetch_en & ~redirect_valid & ((count < FULL) | pop);

  assign imem_addr = fetch_pc;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : `NOP_INSTRUCTION;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
    end else begin
      // Decode saw the handshake even if a redirect throws the entry away.
      if (pop) fetch_count <= fetch_count + 32'd1;

      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ALIGN_MASK;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + addr_t'(4);
          wr_ptr   <= wr_ptr + ptr_t'(1);
        end
        if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // NOTE: the FIFO storage has no reset; occupancy gates every read, so stale
  // contents are never observed and the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: a queue scoreboard of fetched {pc, instr}
// entries plus scenario checks for reset, backpressure, redirects, PC wrap and async reset.

module tb_fetch_controller;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0010_0093;
      32'h0000_0004: return 32'h0020_0113;
      32'h0000_0008: return 32'h0030_8193;
      default:       return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
    endcase
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_controller #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  int          checks = 0;
  int          failures = 0;
  entry_t      sb[$];
  logic [31:0] model_pc;
  logic [31:0] model_fc;
  logic [31:0] delivered[$];

  task automatic model_reset();
    sb.delete();
    model_pc = 32'h0;
    model_fc = 32'h0;
    delivered.delete();
  endtask

  // Enter at a falling edge, return at the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare outputs against the scoreboard head,
  // then advance the reference model the way the edge should advance the DUT.
  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic   exp_valid;
    logic   m_pop;
    logic   m_push;
    entry_t e;
    fetch_en = fe;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    exp_valid = (sb.size() != 0);
    checks++;
    if (imem_addr !== model_pc) begin
      failures++;
      $display("FAIL step_imem_addr t=%0t got=%h exp=%h", $time, imem_addr, model_pc);
    end
    checks++;
    if (out_valid !== exp_valid) begin
      failures++;
      $display("FAIL step_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (out_pc !== sb[0].pc || out_instr !== sb[0].instr) begin
        failures++;
        $display("FAIL step_head t=%0t got pc=%h instr=%h exp pc=%h instr=%h",
                 $time, out_pc, out_instr, sb[0].pc, sb[0].instr);
      end
    end else begin
      checks++;
      if (out_pc !== 32'h0 || out_instr !== NOP) begin
        failures++;
        $display("FAIL step_empty_mask t=%0t got pc=%h instr=%h exp pc=0 instr=%h",
                 $time, out_pc, out_instr, NOP);
      end
    end
    checks++;
    if (fetch_count !== model_fc) begin
      failures++;
      $display("FAIL step_fetch_count t=%0t got=%0d exp=%0d", $time, fetch_count, model_fc);
    end
    if (out_valid === 1'b1 && rdy) delivered.push_back(out_pc);

    m_pop  = exp_valid && rdy;
    m_push = fe && !rv && ((sb.size() < DEPTH) || m_pop);
    if (m_pop) begin
      model_fc = model_fc + 32'd1;
      void'(sb.pop_front());
    end
    if (rv) begin
      sb.delete();
      model_pc = rpc & 32'hFFFF_FFFC;
    end else if (m_push) begin
      e.pc = model_pc;
      e.instr = mem_word(model_pc);
      sb.push_back(e);
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b instr=%h pc=%h exp v=0 instr=%h pc=0",
               out_valid, out_instr, out_pc, NOP);
    end
    checks++;
    if (imem_addr !== 32'h0 || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got addr=%h fc=%0d exp addr=0 fc=0", imem_addr, fetch_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pcs[$];
    exp_pcs = '{32'h0, 32'h4, 32'h8};
    do_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (delivered.size() != 3) begin
      failures++;
      $display("FAIL seq_count got=%0d exp=3", delivered.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (delivered[i] !== exp_pcs[i]) begin
          failures++;
          $display("FAIL seq_pc[%0d] got=%h exp=%h", i, delivered[i], exp_pcs[i]);
        end
      end
    end
    checks++;
    if (fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL seq_fetch_count got=%0d exp=3", fetch_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pcs[$];
    exp_pcs = '{32'h0, 32'h4, 32'h8};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (i >= 1) begin
        checks++;
        if (imem_addr !== 32'h8 || out_pc !== 32'h0 || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold[%0d] got addr=%h pc=%h v=%b exp addr=8 pc=0 v=1",
                   i, imem_addr, out_pc, out_valid);
        end
      end
    end
    delivered.delete();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (delivered.size() != 3) begin
      failures++;
      $display("FAIL bp_release_count got=%0d exp=3", delivered.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (delivered[i] !== exp_pcs[i]) begin
          failures++;
          $display("FAIL bp_release_pc[%0d] got=%h exp=%h", i, delivered[i], exp_pcs[i]);
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    delivered.delete();
    step(1'b1, 1'b0, 1'b1, 32'h0000_0043);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL redir_flush got v=%b addr=%h exp v=0 addr=40", out_valid, imem_addr);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== mem_word(32'h40)) begin
      failures++;
      $display("FAIL redir_target got v=%b pc=%h instr=%h exp v=1 pc=40 instr=%h",
               out_valid, out_pc, out_instr, mem_word(32'h40));
    end
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (delivered.size() == 0 || delivered[0] !== 32'h40) begin
      failures++;
      $display("FAIL redir_first got n=%0d first=%h exp first=40", delivered.size(),
               (delivered.size() != 0) ? delivered[0] : 32'hX);
    end
    foreach (delivered[i]) begin
      checks++;
      if (delivered[i] < 32'h40) begin
        failures++;
        $display("FAIL redir_stale[%0d] got=%h exp>=40", i, delivered[i]);
      end
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    checks++;
    if (fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL redir_pop_count got=%0d exp=1", fetch_count);
    end
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL redir_pop_flush got v=%b addr=%h exp v=0 addr=100", out_valid, imem_addr);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (out_pc !== 32'h100) begin
      failures++;
      $display("FAIL redir_pop_target got=%h exp=100", out_pc);
    end
  endtask

  task automatic test_pc_wrap();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    delivered.delete();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (delivered.size() != 2 || delivered[0] !== 32'hFFFF_FFFC || delivered[1] !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap got n=%0d first=%h second=%h exp FFFFFFFC then 00000000",
               delivered.size(), (delivered.size() > 0) ? delivered[0] : 32'hX,
               (delivered.size() > 1) ? delivered[1] : 32'hX);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_rst_outputs got v=%b instr=%h pc=%h exp v=0 instr=%h pc=0",
               out_valid, out_instr, out_pc, NOP);
    end
    checks++;
    if (imem_addr !== 32'h0 || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL async_rst_state got addr=%h fc=%0d exp addr=0 fc=0", imem_addr, fetch_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_pc_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction fetch sequencer between the core's PC logic and the combinational instruction memory. It owns the fetch PC and drives the memory address. It captures each returned instruction with its PC into a small prefetch FIFO, and presents entries to decode over a valid/ready handshake. Control-flow redirects flush the FIFO and restart fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2: prefetch FIFO entries; power of two, ≥2.

- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; released synchronously by the environment.
- fetch_en  in  1  fetch permitted; 0 freezes the PC and stops pushes, but draining continues.
- imem_addr  out  `DATA_WIDTH  byte address to instruction memory; always equals fetch_pc.
- imem_instr  in  `INSTR_WIDTH  instruction returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  one-cycle redirect strobe from branch/jump resolution.
- redirect_pc  in  `DATA_WIDTH  redirect target; bits [1:0] ignored and forced to 0.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  `INSTR_WIDTH  head instruction; `NOP_INSTRUCTION when out_valid=0.
- out_pc  out  `DATA_WIDTH  PC of head instruction; 0 when out_valid=0.
- fetch_count  out  32  number of completed out handshakes since reset; wraps at 2^32.

## Operation
- State: fetch_pc register, DEPTH-entry FIFO of {pc, instr}, read and write pointers, occupancy count of 0..DEPTH, and the fetch_count register.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop). A push writes {fetch_pc, imem_instr} at the write pointer. On a push, fetch_pc ← fetch_pc + 4, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- When redirect_valid=1, it overrides all other activity that cycle:
  - count ← 0 and both pointers reset to 0;
  - no push occurs;
  - fetch_pc ← {redirect_pc[31:2], 2'b00};
  - the head is discarded even if pop=1.
- fetch_count still increments on a pop in the redirect cycle, because decode observed the handshake.
- Count update: count ← count + push − pop. A simultaneous push and pop when full is legal and count stays DEPTH.
- out_valid = (count != 0). out_instr and out_pc come from the head entry, masked to NOP/0 when empty.
- Pointers wrap modulo DEPTH.
- Out-of-range addresses are not detected here; memory returns NOP, which is fetched normally.
- No instruction is ever duplicated or dropped except by a redirect flush.
- Reset values: fetch_pc=RESET_PC, count=0, pointers=0, fetch_count=0, out_valid=0, out_instr=`NOP_INSTRUCTION, out_pc=0. FIFO data contents are don't-care.
- Asserting rst_n low mid-operation immediately returns all state to the reset values. This is asynchronous and does not wait for a clock edge.

## Timing
- Fetch latency: an instruction pushed at edge N is visible on out_* after edge N with out_valid=1. That is one cycle from imem_addr to out_valid.
- Throughput: one instruction per cycle when fetch_en=1 and out_ready=1 continuously.
- Redirect penalty: strobe at cycle N; edge N+1 flushes and loads the target; the target instruction is pushed at edge N+2; out_valid=1 with out_pc=target after edge N+2.
- Backpressure: with out_ready=0, the FIFO fills to DEPTH; then fetch_pc holds and imem_addr is stable.
- Handshake: out_instr and out_pc stay stable while out_valid=1 and out_ready=0, unless a redirect occurs.

## Test plan
- Reset then sequential fetch:
  - stimulus: RESET_PC=0; mem words 0x00100093, 0x00200113, 0x00308193; fetch_en=1; out_ready=1.
  - required: out_pc 0,4,8 on consecutive cycles with matching instructions, and fetch_count=3.
- Backpressure:
  - stimulus: hold out_ready=0 for 5 cycles.
  - required: count saturates at 2, imem_addr stays at 8, out_pc=0 stays stable; on release, PCs 0,4,8 are delivered without gap or duplicate.
- Redirect:
  - stimulus: redirect_pc=0x0000_0043 while the FIFO is full.
  - required: next cycle out_valid=0; two cycles later out_pc=0x40; the old entries are never delivered.
- Redirect with simultaneous pop:
  - required: fetch_count increments once and the FIFO is still flushed.
- PC wrap:
  - stimulus: redirect to 0xFFFF_FFFC.
  - required: delivered PCs are 0xFFFF_FFFC then 0x0000_0000.
- Async reset mid-stream:
  - stimulus: pull rst_n low between edges with a full FIFO.
  - required: out_valid=0, out_instr=NOP and imem_addr=RESET_PC immediately, before the next clk edge; fetch_count=0.
